gate_test_sequencer: RTL and testbench
======================================

Name: gate_test_sequencer

Overview:
- On-chip self-test controller for the switch-to-LED gate datapath (4-bit switch vector in, 2-bit LED vector out).
- After a start request it drives all 16 switch vectors in ascending order and waits a programmable settle time per vector.
- It samples the 2-bit result, compares it against a parameterised truth table, and reports pass/fail, error count and first failing vector.
- Sits between the board switch inputs and the gate datapath; replaces the simulation-only pattern generator and monitor pair for hardware bring-up.

Parameters:
- SETTLE_CYCLES, 4: clock cycles between driving a vector and sampling the result; legal range 1..255.
- EXP_TABLE, 32'h0000_0000: expected result table; bits [2*v+1 : 2*v] hold the expected led[1:0] for sw vector v (v = 0..15).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request; accepted only in IDLE or DONE.
- abort  input  1  single-cycle request; terminates a run and returns to IDLE.
- led  input  2  result from the gate datapath under test.
- sw  output  4  stimulus vector driven to the gate datapath.
- busy  output  1  high in APPLY, SETTLE and CHECK.
- done  output  1  high in DONE.
- pass  output  1  valid while done=1; high when err_cnt==0.
- err_cnt  output  5  number of mismatching vectors in the current or last run (0..16).
- err_valid  output  1  high once at least one mismatch is recorded in the current run.
- first_err_vec  output  4  sw value of the first mismatch.
- first_err_led  output  2  led value sampled at the first mismatch.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; sw=0, busy=0, done=0, pass=0, err_cnt=0, err_valid=0, first_err_vec=0, first_err_led=0; internal vec=0, settle counter=0.
- All outputs are registered.
- IDLE: sw=0. start=1 -> APPLY; in the same edge clear err_cnt, err_valid, first_err_*, pass; set vec=0.
- APPLY (1 cycle): sw<=vec; load settle counter with SETTLE_CYCLES-1 -> SETTLE.
- SETTLE: decrement each cycle; at 0 -> CHECK. Duration is exactly SETTLE_CYCLES cycles.
- CHECK (1 cycle): compare led against EXP_TABLE[2*vec +: 2].
  - On mismatch: err_cnt++. If err_valid==0, capture first_err_vec=vec and first_err_led=led, then set err_valid=1.
  - If vec==15 -> DONE; else vec++ -> APPLY.
- Run timing: sw changes at the APPLY->SETTLE edge and holds through CHECK. Per-vector time is SETTLE_CYCLES+2 cycles. done rises exactly 16*(SETTLE_CYCLES+2) cycles after the edge that accepted start.
- DONE: done=1, pass=(err_cnt==0), sw holds 15. Results hold until the next start.
  - start -> APPLY with the same clearing as from IDLE.
  - abort -> IDLE, which clears done and pass.
- abort in APPLY/SETTLE/CHECK: next state IDLE, sw=0, busy=0, done=0. err_cnt and first_err_* keep their partial values; pass=0.
- start while busy is ignored.
- start and abort in the same cycle: abort wins in every state.
- err_cnt cannot overflow: 16 is the maximum, since each vector is checked once per run.
- vec counter is 4 bits and never wraps during a run; the exit is taken at 15.

Optional Feature:
- Macro SEQ_STOP_ON_ERR_EN.
  - Defined: the first mismatch in CHECK goes directly to DONE with err_cnt=1, pass=0, sw held at the failing vector, and first_err_* captured.
  - Undefined: all 16 vectors are always run and every mismatch is counted.

Test Plan:
- Reset mid-SETTLE of vector 7: assert rst_n=0 -> all outputs read 0 immediately (asynchronously), state IDLE; the next start runs from vec 0.
- Bench model led0=sw0&sw1, led1=sw2|sw3, EXP_TABLE built to match, SETTLE_CYCLES=4: pulse start -> sw steps 0..15; done=1 exactly 96 cycles after accept; pass=1, err_cnt=0, err_valid=0.
- Same table, model with led1 stuck at 0 -> err_cnt=12, err_valid=1, first_err_vec=4, first_err_led=2'b00, pass=0.
- Abort during vector 5: start and abort asserted together -> nothing happens. Later, abort at vector 5 -> IDLE next cycle, sw=0, busy=0, done=0. A second start during a run is ignored (done still at cycle 96 of the first run).
- SETTLE_CYCLES=1, restart from DONE: start in DONE -> results cleared on the same edge; new done after 48 cycles.
- With SEQ_STOP_ON_ERR_EN defined, stuck-at model above -> done at cycle 5*6=30 after accept; err_cnt=1, sw=4, first_err_vec=4.

Source files
------------

// File: rtl/gate_test_sequencer_if.sv
// Handshake and result bundle between the gate test sequencer and its host / datapath.
interface gate_test_sequencer_if;
  logic       start;
  logic       abort;
  logic [1:0] led;
  logic [3:0] sw;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] err_cnt;
  logic       err_valid;
  logic [3:0] first_err_vec;
  logic [1:0] first_err_led;

  modport master (
    output start, abort, led,
    input  sw, busy, done, pass, err_cnt, err_valid, first_err_vec, first_err_led
  );

  modport slave (
    input  start, abort, led,
    output sw, busy, done, pass, err_cnt, err_valid, first_err_vec, first_err_led
  );
endinterface

// File: rtl/gate_test_sequencer.sv
// Self-test sequencer: sweeps sw 0..15, settles, checks led against EXP_TABLE.
// Optional macro SEQ_STOP_ON_ERR_EN ends the run at the first mismatch.
module gate_test_sequencer #(
  parameter int          SETTLE_CYCLES = 4,
  parameter logic [31:0] EXP_TABLE     = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  gate_test_sequencer_if.slave  bus
);

  // state  | meaning
  // IDLE   | waiting for start, sw forced to 0
  // APPLY  | drive current vector, load settle timer
  // SETTLE | timer counts down to 0
  // CHECK  | compare led with expected entry, advance or finish
  // DONE   | results held until next start or abort
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    APPLY  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t     state;
  logic [3:0] vec;
  logic [7:0] settle_cnt;
  logic [3:0] sw_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;
  logic [4:0] err_cnt_q;
  logic       err_valid_q;
  logic [3:0] first_err_vec_q;
  logic [1:0] first_err_led_q;

  logic [1:0] exp_led;
  logic       mismatch;
  logic [4:0] err_cnt_nxt;
  logic       last_vec;

  assign exp_led     = EXP_TABLE[{vec, 1'b0} +: 2];
  assign mismatch    = (bus.led != exp_led);
  assign err_cnt_nxt = err_cnt_q + {4'd0, mismatch};

`ifdef SEQ_STOP_ON_ERR_EN
  assign last_vec = (vec == 4'd15) || mismatch;
`else
  assign last_vec = (vec == 4'd15);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      vec             <= 4'd0;
      settle_cnt      <= 8'd0;
      sw_q            <= 4'd0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
      err_cnt_q       <= 5'd0;
      err_valid_q     <= 1'b0;
      first_err_vec_q <= 4'd0;
      first_err_led_q <= 2'd0;
    end else if (bus.abort) begin
      // abort beats start everywhere; partial error results stay visible
      state  <= IDLE;
      sw_q   <= 4'd0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state           <= APPLY;
            vec             <= 4'd0;
            busy_q          <= 1'b1;
            done_q          <= 1'b0;
            pass_q          <= 1'b0;
            err_cnt_q       <= 5'd0;
            err_valid_q     <= 1'b0;
            first_err_vec_q <= 4'd0;
            first_err_led_q <= 2'd0;
          end
        end
        APPLY: begin
          sw_q       <= vec;
          settle_cnt <= 8'(SETTLE_CYCLES - 1);
          state      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == 8'd0) begin
            state <= CHECK;
          end else begin
            settle_cnt <= settle_cnt - 8'd1;
          end
        end
        CHECK: begin
          err_cnt_q <= err_cnt_nxt;
          if (mismatch && !err_valid_q) begin
            first_err_vec_q <= vec;
            first_err_led_q <= bus.led;
            err_valid_q     <= 1'b1;
          end
          if (last_vec) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            pass_q <= (err_cnt_nxt == 5'd0);
          end else begin
            vec   <= vec + 4'd1;
            state <= APPLY;
          end
        end
        default: begin
          state  <= IDLE;
          sw_q   <= 4'd0;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          pass_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sw            = sw_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.err_cnt       = err_cnt_q;
  assign bus.err_valid     = err_valid_q;
  assign bus.first_err_vec = first_err_vec_q;
  assign bus.first_err_led = first_err_led_q;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Directed bench for gate_test_sequencer: two instances (settle 4 and settle 1) driven by a gate model.
module tb_gate_test_sequencer;

  localparam logic [31:0] EXP = 32'hEAEA_EA40;

  logic clk;
  logic rst_n;
  logic stuck;
  logic use_b;
  int   vectors;
  int   miscompares;

  gate_test_sequencer_if ifa ();
  gate_test_sequencer_if ifb ();

  gate_test_sequencer #(.SETTLE_CYCLES(4), .EXP_TABLE(EXP)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.slave)
  );

  gate_test_sequencer #(.SETTLE_CYCLES(1), .EXP_TABLE(EXP)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb.slave)
  );

  function automatic logic [1:0] gate_model(input logic [3:0] s, input logic stk);
    return {stk ? 1'b0 : (s[2] | s[3]), s[0] & s[1]};
  endfunction

  assign ifa.led = gate_model(ifa.sw, stuck);
  assign ifb.led = gate_model(ifb.sw, stuck);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (use_b) ifb.start = v;
    else       ifa.start = v;
  endtask

  function automatic logic [3:0] cur_sw();
    return use_b ? ifb.sw : ifa.sw;
  endfunction
  function automatic logic cur_done();
    return use_b ? ifb.done : ifa.done;
  endfunction
  function automatic logic cur_busy();
    return use_b ? ifb.busy : ifa.busy;
  endfunction
  function automatic logic [4:0] cur_err();
    return use_b ? ifb.err_cnt : ifa.err_cnt;
  endfunction
  function automatic logic cur_err_valid();
    return use_b ? ifb.err_valid : ifa.err_valid;
  endfunction

  // Pulse start, then count edges until done; optional second start at edge extra_k.
  task automatic run(input int settle, input int exp_cyc, input int extra_k);
    int k;
    set_start(1'b1);
    @(posedge clk); #1;
    set_start(1'b0);
    chk("accept_busy", cur_busy(), 1'b1);
    chk("accept_done", cur_done(), 1'b0);
    chk("accept_err_cnt", cur_err(), 5'd0);
    chk("accept_err_valid", cur_err_valid(), 1'b0);
    k = 0;
    while (k < 2000) begin
      @(posedge clk); #1;
      k++;
      if (k == extra_k)     set_start(1'b1);
      if (k == extra_k + 1) set_start(1'b0);
      if (cur_done()) break;
      if ((k - 1) % (settle + 2) == 0)
        chk("sw_step", cur_sw(), 32'((k - 1) / (settle + 2)));
    end
    chk("done_cycle", k, exp_cyc);
  endtask

  initial begin
    int k;
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    stuck       = 1'b0;
    use_b       = 1'b0;
    ifa.start = 1'b0; ifa.abort = 1'b0;
    ifb.start = 1'b0; ifb.abort = 1'b0;

    #12;
    chk("rst_sw", ifa.sw, 4'd0);
    chk("rst_busy", ifa.busy, 1'b0);
    chk("rst_done", ifa.done, 1'b0);
    chk("rst_pass", ifa.pass, 1'b0);
    chk("rst_err_cnt", ifa.err_cnt, 5'd0);
    chk("rst_err_valid", ifa.err_valid, 1'b0);
    chk("rst_first_vec", ifa.first_err_vec, 4'd0);
    chk("rst_first_led", ifa.first_err_led, 2'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // reset asserted while vector 7 is settling
    ifa.start = 1'b1;
    @(posedge clk); #1;
    ifa.start = 1'b0;
    for (int i = 0; i < 45; i++) begin
      @(posedge clk); #1;
    end
    chk("mid_run_sw", ifa.sw, 4'd7);
    chk("mid_run_busy", ifa.busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_sw", ifa.sw, 4'd0);
    chk("async_rst_busy", ifa.busy, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // clean run with an ignored start mid-run
    run(4, 96, 50);
    chk("clean_pass", ifa.pass, 1'b1);
    chk("clean_err_cnt", ifa.err_cnt, 5'd0);
    chk("clean_err_valid", ifa.err_valid, 1'b0);
    chk("clean_sw_hold", ifa.sw, 4'd15);
    chk("clean_busy", ifa.busy, 1'b0);

    ifa.abort = 1'b1;
    @(posedge clk); #1;
    ifa.abort = 1'b0;
    chk("abort_done_done", ifa.done, 1'b0);
    chk("abort_done_pass", ifa.pass, 1'b0);
    chk("abort_done_sw", ifa.sw, 4'd0);

    // led1 stuck at 0
    stuck = 1'b1;
`ifdef SEQ_STOP_ON_ERR_EN
    run(4, 30, 0);
    chk("stuck_err_cnt", ifa.err_cnt, 5'd1);
    chk("stuck_sw", ifa.sw, 4'd4);
`else
    run(4, 96, 0);
    chk("stuck_err_cnt", ifa.err_cnt, 5'd12);
    chk("stuck_sw", ifa.sw, 4'd15);
`endif
    chk("stuck_err_valid", ifa.err_valid, 1'b1);
    chk("stuck_first_vec", ifa.first_err_vec, 4'd4);
    chk("stuck_first_led", ifa.first_err_led, 2'b00);
    chk("stuck_pass", ifa.pass, 1'b0);

    ifa.abort = 1'b1;
    @(posedge clk); #1;
    ifa.abort = 1'b0;
    ifa.start = 1'b1;
    ifa.abort = 1'b1;
    @(posedge clk); #1;
    ifa.start = 1'b0;
    ifa.abort = 1'b0;
    @(posedge clk); #1;
    chk("both_busy", ifa.busy, 1'b0);
    chk("both_done", ifa.done, 1'b0);
`ifdef SEQ_STOP_ON_ERR_EN
    chk("both_err_kept", ifa.err_cnt, 5'd1);
`else
    chk("both_err_kept", ifa.err_cnt, 5'd12);
`endif

    // abort during vector 5 keeps partial error results
    ifa.start = 1'b1;
    @(posedge clk); #1;
    ifa.start = 1'b0;
    for (k = 0; k < 33; k++) begin
      @(posedge clk); #1;
    end
    ifa.abort = 1'b1;
    @(posedge clk); #1;
    ifa.abort = 1'b0;
    chk("abort5_sw", ifa.sw, 4'd0);
    chk("abort5_busy", ifa.busy, 1'b0);
    chk("abort5_done", ifa.done, 1'b0);
    chk("abort5_pass", ifa.pass, 1'b0);
    chk("abort5_err_cnt", ifa.err_cnt, 5'd1);
    chk("abort5_err_valid", ifa.err_valid, 1'b1);
    chk("abort5_first_vec", ifa.first_err_vec, 4'd4);

    // settle=1 instance: failing run, then restart from DONE with a good datapath
    use_b = 1'b1;
`ifdef SEQ_STOP_ON_ERR_EN
    run(1, 15, 0);
    chk("b_stuck_err_cnt", ifb.err_cnt, 5'd1);
`else
    run(1, 48, 0);
    chk("b_stuck_err_cnt", ifb.err_cnt, 5'd12);
`endif
    chk("b_stuck_done", ifb.done, 1'b1);
    stuck = 1'b0;
    run(1, 48, 0);
    chk("b_restart_pass", ifb.pass, 1'b1);
    chk("b_restart_err_cnt", ifb.err_cnt, 5'd0);
    chk("b_restart_first_vec", ifb.first_err_vec, 4'd0);
    chk("b_restart_sw", ifb.sw, 4'd15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
